dmem_unit: RTL and testbench

DMEM_UNIT -- requirements
Module: dmem_unit

---
 rtl/dmem_pkg.sv | 16 +
 rtl/dmem_array.sv | 25 ++
 rtl/dmem_unit.sv | 150 +++++++++++++++
 tb/tb_dmem_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory unit: FSM encoding, fault codes and defaults.
package dmem_pkg;

  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_MISALIGN = 2'b01;
  localparam logic [1:0] FC_RANGE    = 2'b10;
  localparam logic [1:0] FC_CONFLICT = 2'b11;

  localparam logic [31:0] DEF_BASE_ADDR   = 32'h1001_0000;
  localparam int unsigned DEF_DEPTH_WORDS = 1024;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with registered read data; deliberately not reset.
module dmem_array #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] idx_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // Read register only moves on an accepted load so the result holds until the next one.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[idx_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[idx_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_unit.sv
// Data-memory unit: post-reset clear sweep, checked load/store access, sticky first-fault log.
module dmem_unit
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dAddress,
  input  logic [31:0] dWriteData,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] dReadData,
  output logic        rd_valid,
  output logic        init_done,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] fault_addr,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  localparam int unsigned AW   = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] sweep_q, sweep_d;
  logic          rd_valid_q, rd_valid_d;
  logic          init_done_q, init_done_d;
  logic          rd_loaded_q, rd_loaded_d;
  logic          fault_q, fault_d;
  logic [1:0]    fault_cause_q, fault_cause_d;
  logic [31:0]   fault_addr_q, fault_addr_d;
  logic [15:0]   rd_count_q, rd_count_d;
  logic [15:0]   wr_count_q, wr_count_d;

  logic [31:0]   offset;
  logic          misaligned, out_of_range, conflict, req, active, legal;
  logic          acc_rd, acc_wr, fault_evt;
  logic [1:0]    cause;
  logic          arr_we;
  logic [AW-1:0] arr_idx;
  logic [31:0]   arr_wdata, arr_rdata;

  assign offset       = dAddress - BASE_ADDR;
  assign misaligned   = |dAddress[1:0];
  assign out_of_range = (dAddress < BASE_ADDR) || ({1'b0, offset} >= SPAN);
  assign conflict     = MemRead & MemWrite;
  assign req          = MemRead | MemWrite;
  assign active       = (state_q != ST_CLEAR);
  assign legal        = active & req & ~misaligned & ~out_of_range & ~conflict;
  assign acc_rd       = legal & MemRead;
  assign acc_wr       = legal & MemWrite;
  assign fault_evt    = req & (~active | misaligned | out_of_range | conflict);

  always_comb begin
    if (!active)           cause = FC_CONFLICT;
    else if (misaligned)   cause = FC_MISALIGN;
    else if (out_of_range) cause = FC_RANGE;
    else                   cause = FC_CONFLICT;
  end

  // The sweep owns the single RAM port while clearing; requests are locked out then.
  assign arr_we    = active ? acc_wr : 1'b1;
  assign arr_idx   = active ? offset[AW+1:2] : sweep_q;
  assign arr_wdata = active ? dWriteData : '0;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk    (clk),
    .we_i   (arr_we),
    .re_i   (acc_rd),
    .idx_i  (arr_idx),
    .wdata_i(arr_wdata),
    .rdata_o(arr_rdata)
  );

  always_comb begin
    state_d       = state_q;
    sweep_d       = sweep_q;
    init_done_d   = init_done_q;
    rd_loaded_d   = rd_loaded_q | acc_rd;
    rd_valid_d    = active & MemRead;
    fault_d       = fault_q;
    fault_cause_d = fault_cause_q;
    fault_addr_d  = fault_addr_q;
    rd_count_d    = rd_count_q;
    wr_count_d    = wr_count_q;

    case (state_q)
      ST_CLEAR: begin
        sweep_d = sweep_q + AW'(1);
        if (sweep_q == AW'(DEPTH_WORDS - 1)) begin
          state_d     = ST_IDLE;
          init_done_d = 1'b1;
        end
      end
      default: state_d = acc_rd ? ST_RESP : ST_IDLE;
    endcase

    if (fault_evt && !fault_q) begin
      fault_d       = 1'b1;
      fault_cause_d = cause;
      fault_addr_d  = dAddress;
    end

    if (acc_rd && rd_count_q != '1) rd_count_d = rd_count_q + 16'd1;
    if (acc_wr && wr_count_q != '1) wr_count_d = wr_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_CLEAR;
      sweep_q       <= '0;
      rd_valid_q    <= 1'b0;
      init_done_q   <= 1'b0;
      rd_loaded_q   <= 1'b0;
      fault_q       <= 1'b0;
      fault_cause_q <= FC_NONE;
      fault_addr_q  <= '0;
      rd_count_q    <= '0;
      wr_count_q    <= '0;
    end else begin
      state_q       <= state_d;
      sweep_q       <= sweep_d;
      rd_valid_q    <= rd_valid_d;
      init_done_q   <= init_done_d;
      rd_loaded_q   <= rd_loaded_d;
      fault_q       <= fault_d;
      fault_cause_q <= fault_cause_d;
      fault_addr_q  <= fault_addr_d;
      rd_count_q    <= rd_count_d;
      wr_count_q    <= wr_count_d;
    end
  end

  // The unreset RAM read register is masked until the first accepted load.
  assign dReadData   = rd_loaded_q ? arr_rdata : '0;
  assign rd_valid    = rd_valid_q;
  assign init_done   = init_done_q;
  assign fault       = fault_q;
  assign fault_cause = fault_cause_q;
  assign fault_addr  = fault_addr_q;
  assign rd_count    = rd_count_q;
  assign wr_count    = wr_count_q;

endmodule

// File: tb/tb_dmem_unit.sv
// Directed bench for dmem_unit: cycle model compared every cycle, plus literal spot checks.
module tb_dmem_unit;

  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam int unsigned DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dAddress, dWriteData;
  logic        MemRead, MemWrite;
  logic [31:0] dReadData;
  logic        rd_valid, init_done, fault;
  logic [1:0]  fault_cause;
  logic [31:0] fault_addr;
  logic [15:0] rd_count, wr_count;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  dmem_unit #(
    .BASE_ADDR  (BASE),
    .DEPTH_WORDS(DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .dAddress   (dAddress),
    .dWriteData (dWriteData),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .dReadData  (dReadData),
    .rd_valid   (rd_valid),
    .init_done  (init_done),
    .fault      (fault),
    .fault_cause(fault_cause),
    .fault_addr (fault_addr),
    .rd_count   (rd_count),
    .wr_count   (wr_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: memory is an array, the sweep is just a countdown of cycles left.
  bit          model_ok = 1'b0;
  logic [31:0] m_mem [DEPTH];
  int          m_clear_left;
  logic [31:0] m_rdata, m_faddr;
  bit          m_rv, m_done, m_fault;
  logic [1:0]  m_cause;
  int          m_rc, m_wc;

  always @(posedge clk) begin : model
    longint a;
    bit     mis, inr, conf, rq;
    int     idx;
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
      m_clear_left = DEPTH;
      m_rdata = 0; m_rv = 0; m_done = 0; m_fault = 0;
      m_cause = 0; m_faddr = 0; m_rc = 0; m_wc = 0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      rq = MemRead || MemWrite;
      m_rv = 0;
      if (m_clear_left > 0) begin
        if (rq && !m_fault) begin
          m_fault = 1; m_cause = 2'b11; m_faddr = dAddress;
        end
        m_clear_left--;
        if (m_clear_left == 0) m_done = 1;
      end else begin
        a    = longint'(dAddress);
        mis  = (dAddress % 4) != 0;
        inr  = (a >= longint'(BASE)) && (a < longint'(BASE) + 4 * DEPTH);
        conf = MemRead && MemWrite;
        if (rq) begin
          if (mis || !inr || conf) begin
            if (!m_fault) begin
              m_fault = 1;
              m_cause = mis ? 2'b01 : (!inr ? 2'b10 : 2'b11);
              m_faddr = dAddress;
            end
          end else begin
            idx = int'((a - longint'(BASE)) / 4);
            if (MemWrite) begin
              m_mem[idx] = dWriteData;
              if (m_wc < 65535) m_wc++;
            end else begin
              m_rdata = m_mem[idx];
              if (m_rc < 65535) m_rc++;
            end
          end
        end
        m_rv = MemRead;
      end
    end
  end

  always @(negedge clk) begin : compare
    if (model_ok) begin
      check("dReadData",   dReadData,           m_rdata);
      check("rd_valid",    32'(rd_valid),       32'(m_rv));
      check("init_done",   32'(init_done),      32'(m_done));
      check("fault",       32'(fault),          32'(m_fault));
      check("fault_cause", 32'(fault_cause),    32'(m_cause));
      check("fault_addr",  fault_addr,          m_faddr);
      check("rd_count",    32'(rd_count),       32'(m_rc));
      check("wr_count",    32'(wr_count),       32'(m_wc));
    end
  end

  task automatic idle_in();
    MemRead = 0; MemWrite = 0; dAddress = 0; dWriteData = 0;
  endtask

  // Called just after a negedge; returns at the negedge after the request edge.
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    MemRead = rd; MemWrite = wr; dAddress = a; dWriteData = d;
    @(negedge clk);
    idle_in();
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (!init_done && n < 2000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_reset();
    int n;
    rst = 0;
    idle_in();
    repeat (2) @(negedge clk);
    check("rst_dReadData", dReadData, 32'h0);
    check("rst_init_done", 32'(init_done), 32'h0);
    check("rst_fault", 32'(fault), 32'h0);
    check("rst_counts", {rd_count, wr_count}, 32'h0);
    rst = 1;
    wait_init(n);
    check("init_latency", n, 1024);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n;
    rst = 0;
    idle_in();
    @(negedge clk);

    // Sweep latency and a zeroed read
    do_reset();
    do_req(1, 0, 32'h1001_0010, 0);
    check("zero_load_data", dReadData, 32'h0);
    check("zero_load_valid", 32'(rd_valid), 32'h1);

    // Store then immediate load
    do_reset();
    do_req(0, 1, 32'h1001_0004, 32'hDEAD_BEEF);
    do_req(1, 0, 32'h1001_0004, 0);
    check("st_ld_data", dReadData, 32'hDEAD_BEEF);
    check("st_ld_valid", 32'(rd_valid), 32'h1);
    check("st_ld_counts", {rd_count, wr_count}, 32'h0001_0001);
    @(negedge clk);
    check("st_ld_pulse_end", 32'(rd_valid), 32'h0);

    // Misaligned load
    do_req(1, 0, 32'h1001_0006, 0);
    check("mis_fault", 32'(fault), 32'h1);
    check("mis_cause", 32'(fault_cause), 32'h1);
    check("mis_addr", fault_addr, 32'h1001_0006);
    check("mis_valid", 32'(rd_valid), 32'h1);
    check("mis_data", dReadData, 32'hDEAD_BEEF);
    check("mis_counts", {rd_count, wr_count}, 32'h0001_0001);

    // Out-of-range store, then a misaligned access that must not overwrite the log
    do_reset();
    do_req(0, 1, 32'h1001_0000, 32'h1234_5678);
    do_req(0, 1, 32'h1001_1000, 32'hFFFF_FFFF);
    check("oor_cause", 32'(fault_cause), 32'h2);
    check("oor_addr", fault_addr, 32'h1001_1000);
    check("oor_wr_count", 32'(wr_count), 32'h1);
    do_req(1, 0, 32'h1001_0002, 0);
    check("sticky_cause", 32'(fault_cause), 32'h2);
    check("sticky_addr", fault_addr, 32'h1001_1000);
    do_req(1, 0, 32'h1001_0000, 0);
    check("oor_mem_kept", dReadData, 32'h1234_5678);

    // Read+write conflict
    do_reset();
    do_req(1, 1, 32'h1001_0000, 32'hAAAA_AAAA);
    check("conf_cause", 32'(fault_cause), 32'h3);
    check("conf_addr", fault_addr, 32'h1001_0000);
    check("conf_counts", {rd_count, wr_count}, 32'h0);
    do_req(1, 0, 32'h1001_0000, 0);
    check("conf_no_write", dReadData, 32'h0);

    // Request during the sweep
    rst = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    repeat (5) @(negedge clk);
    do_req(1, 0, 32'h1001_0000, 0);
    check("busy_fault", 32'(fault), 32'h1);
    check("busy_cause", 32'(fault_cause), 32'h3);
    check("busy_valid", 32'(rd_valid), 32'h0);
    wait_init(n);
    check("busy_init_latency", n + 6, 1024);

    // Reset mid-sweep restarts from index 0
    rst = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    repeat (300) @(negedge clk);
    check("mid_sweep_init", 32'(init_done), 32'h0);
    rst = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    wait_init(n);
    check("restart_latency", n, 1024);

    // Back-to-back loads held in RESP
    do_req(0, 1, 32'h1001_0004, 32'h1111_1111);
    do_req(0, 1, 32'h1001_0008, 32'h2222_2222);
    do_req(0, 1, 32'h1001_000C, 32'h3333_3333);
    MemRead = 1; dAddress = 32'h1001_0004;
    @(negedge clk);
    check("b2b_1_valid", 32'(rd_valid), 32'h1);
    check("b2b_1_data", dReadData, 32'h1111_1111);
    dAddress = 32'h1001_0008;
    @(negedge clk);
    check("b2b_2_valid", 32'(rd_valid), 32'h1);
    check("b2b_2_data", dReadData, 32'h2222_2222);
    dAddress = 32'h1001_000C;
    @(negedge clk);
    check("b2b_3_valid", 32'(rd_valid), 32'h1);
    check("b2b_3_data", dReadData, 32'h3333_3333);
    idle_in();
    @(negedge clk);
    check("b2b_end_valid", 32'(rd_valid), 32'h0);
    check("b2b_hold_data", dReadData, 32'h3333_3333);
    check("b2b_counts", {rd_count, wr_count}, 32'h0003_0003);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
